transition_logger: RTL and testbench

- Receive-side companion to the wire/reg stimulus demos: it observes a driven net and records every value change.
- Each change is pushed as a {timestamp, new value} record into an internal first-word-fall-through FIFO.
- A downstream reader drains the FIFO through a valid/ready handshake.
- Sits between stimulus logic and any checker or display logic that consumes the records.

---
 rtl/transition_logger.sv | 134 +++++++++++++
 tb/tb_transition_logger.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/transition_logger.sv
// transition_logger: logs every value change of sig_in as a {timestamp, value}
// record into a first-word-fall-through FIFO drained by a valid/ready reader.
module transition_logger #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           sig_in,
  input  logic                       rd_ready,
  input  logic                       clr_overflow,
  output logic                       rd_valid,
  output logic [TS_W-1:0]            rd_ts,
  output logic [WIDTH-1:0]           rd_value,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] value;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             head_q;
  rec_t             new_rec;
  rec_t             head_nxt;

  logic [TS_W-1:0]  ts_q;
  logic             armed;
  logic [WIDTH-1:0] last_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_nxt;
  logic             ovf_q;
  logic [7:0]       drop_q;

  logic             change;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;

  // Event detection, push/pop/drop decisions and next head record
  always_comb begin
    new_rec   = '{ts: ts_q, value: sig_in};
    change    = armed && (sig_in != last_q);
    pop       = (level_q != '0) && rd_ready;
    full      = (level_q == LW'(DEPTH));
    push      = change && (!full || pop);
    drop      = change && full && !pop;
    rd_nxt    = rd_ptr + PW'(pop);
    level_nxt = level_q + LW'(push) - LW'(pop);
    // The slot being written becomes head only when the FIFO was
    // effectively empty after this edge's pop.
    if (push && (rd_nxt == wr_ptr)) begin
      head_nxt = new_rec;
    end else begin
      head_nxt = mem[rd_nxt];
    end
  end

  // Free-running timestamp and baseline capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q   <= '0;
      armed  <= 1'b0;
      last_q <= '0;
    end else begin
      ts_q   <= ts_q + 1'b1;
      armed  <= 1'b1;
      last_q <= sig_in;
    end
  end

  // Record storage; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  // Pointers, occupancy and registered head presentation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_nxt;
      level_q <= level_nxt;
      if (level_nxt != '0) begin
        head_q <= head_nxt;
      end
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (clr_overflow) begin
        drop_q <= 8'd1;
      end else if (drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end else if (clr_overflow) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end
  end

  assign rd_valid = (level_q != '0);
  assign rd_ts    = head_q.ts;
  assign rd_value = head_q.value;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_transition_logger.sv
// tb_transition_logger: directed and random checks of transition_logger
// against a queue-based reference model.
module tb_transition_logger;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int TS_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] sig_in = '0;
  logic             rd_ready = 1'b0;
  logic             clr_overflow = 1'b0;
  logic             rd_valid;
  logic [TS_W-1:0]  rd_ts;
  logic [WIDTH-1:0] rd_value;
  logic [2:0]       level;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [11:0] q [$];
  int          m_ts = 0;
  bit          m_armed = 0;
  logic [3:0]  m_last = '0;
  bit          m_ovf = 0;
  int          m_dc = 0;
  logic [11:0] m_head = '0;

  transition_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .rd_ready(rd_ready),
    .clr_overflow(clr_overflow),
    .rd_valid(rd_valid),
    .rd_ts(rd_ts),
    .rd_value(rd_value),
    .level(level),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] s, input bit rdy,
                            input bit clr, input bit rst);
    bit pop;
    bit ev;
    bit dropped;
    logic [11:0] rec;
    if (rst) begin
      q.delete();
      m_ts = 0;
      m_armed = 0;
      m_last = '0;
      m_ovf = 0;
      m_dc = 0;
      m_head = '0;
    end else begin
      pop = (q.size() > 0) && rdy;
      ev = m_armed && (s != m_last);
      dropped = 0;
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) begin
          rec = {m_ts[7:0], s};
          q.push_back(rec);
        end else begin
          dropped = 1;
        end
      end
      if (dropped) begin
        m_ovf = 1;
        m_dc = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (clr) begin
        m_ovf = 0;
        m_dc = 0;
      end
      m_last = s;
      m_armed = 1;
      m_ts = (m_ts + 1) % 256;
      if (q.size() > 0) m_head = q[0];
    end
  endtask

  task automatic step(input logic [3:0] s, input bit rdy,
                      input bit clr, input bit rst);
    sig_in = s;
    rd_ready = rdy;
    clr_overflow = clr;
    rst_n = !rst;
    @(posedge clk);
    model_edge(s, rdy, clr, rst);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("rd_ts", 32'(rd_ts), 32'(m_head[11:4]));
    chk("rd_value", 32'(rd_value), 32'(m_head[3:0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
  endtask

  logic [3:0] cur;

  initial begin
    // reset and baseline
    step(4'h0, 0, 0, 1);
    step(4'h0, 0, 0, 1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ts", 32'(rd_ts), 32'd0);
    for (int i = 0; i < 10; i++) step(4'h3, 0, 0, 0);
    chk("base_valid", 32'(rd_valid), 32'd0);
    chk("base_level", 32'(level), 32'd0);

    // single change at ts_q=5
    step(4'h3, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(4'h3, 1, 0, 0);
    step(4'h5, 1, 0, 0);
    chk("single_valid", 32'(rd_valid), 32'd1);
    chk("single_ts", 32'(rd_ts), 32'd5);
    chk("single_val", 32'(rd_value), 32'd5);
    step(4'h5, 1, 0, 0);
    chk("single_pop", 32'(level), 32'd0);

    // fill and drop: records at ts 7..10, two drops
    for (int i = 0; i < 6; i++) step((i % 2) ? 4'hF : 4'h0, 0, 0, 0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_drop", 32'(drop_cnt), 32'd2);
    chk("fill_head", 32'(rd_ts), 32'd7);
    step(4'hF, 0, 1, 0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // full with simultaneous pop and push at ts 14
    step(4'h0, 1, 0, 0);
    chk("fullpop_level", 32'(level), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("drain0", 32'(rd_ts), 32'd8);
    step(4'h0, 1, 0, 0);
    chk("drain1", 32'(rd_ts), 32'd9);
    step(4'h0, 1, 0, 0);
    chk("drain2", 32'(rd_ts), 32'd10);
    step(4'h0, 1, 0, 0);
    chk("drain3_ts", 32'(rd_ts), 32'd14);
    chk("drain3_val", 32'(rd_value), 32'd0);
    step(4'h0, 1, 0, 0);
    chk("drained", 32'(rd_valid), 32'd0);

    // timestamp wrap
    while (m_ts != 255) step(4'h0, 1, 0, 0);
    step(4'h9, 0, 0, 0);
    step(4'hA, 0, 0, 0);
    chk("wrap_first", 32'(rd_ts), 32'd255);
    step(4'hA, 1, 0, 0);
    chk("wrap_second", 32'(rd_ts), 32'd0);
    step(4'hA, 1, 0, 0);

    // drop counter saturation, then drop racing a clear
    for (int i = 0; i < 4; i++) step(4'(i), 0, 0, 0);
    for (int i = 0; i < 300; i++) step((i % 2) ? 4'hC : 4'hD, 0, 0, 0);
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    step(4'h1, 0, 1, 0);
    chk("race_ovf", 32'(overflow), 32'd1);
    chk("race_drop", 32'(drop_cnt), 32'd1);
    step(4'h1, 0, 1, 0);
    chk("clr2_drop", 32'(drop_cnt), 32'd0);

    // reset mid-operation
    for (int i = 0; i < 4; i++) step(4'h1, 1, 0, 0);
    step(4'h2, 0, 0, 0);
    step(4'h3, 0, 0, 0);
    step(4'h4, 0, 0, 0);
    chk("mid_level3", 32'(level), 32'd3);
    step(4'h4, 0, 0, 1);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_valid", 32'(rd_valid), 32'd0);
    step(4'h4, 0, 0, 0);
    step(4'h6, 0, 0, 0);
    chk("rearm_ts", 32'(rd_ts), 32'd1);
    chk("rearm_val", 32'(rd_value), 32'd6);

    // randomized traffic
    cur = 4'h6;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) cur = 4'($urandom);
      step(cur,
           ((i / 100) % 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
